token_run_packer: RTL and testbench
===================================

# token_run_packer

Downstream stage of the token-doubling stage. Consumes its serial token stream and overflow flag, measures the length of every run of consecutive '1' tokens, and queues each completed run length in a small FIFO. Lengths are presented to the next stage over a valid/ready handshake. This converts the 1-bit-per-cycle stream into one word per run, for counting and checking.

## Interface

Parameters:
- W, default 8: run-length word width; the length counter saturates at 2^W-1.
- DEPTH, default 4: FIFO depth in entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset; rst==0 at a rising edge resets all state.
- a  in  1  serial token stream; one token per cycle, sampled every cycle.
- up_overflow  in  1  overflow flag from the upstream doubling stage.
- len_data  out  W  run length at the FIFO head.
- len_valid  out  1  high when the FIFO is non-empty.
- len_ready  in  1  consumer accepts len_data when len_valid && len_ready at an edge.
- lost  out  1  sticky flag: a completed run was dropped because the FIFO was full.
- halted  out  1  sticky flag: up_overflow has been seen and capture has stopped.

## Operation

- Run counter `cnt` (W bits):
  - When a==1: cnt <= cnt+1, saturating at 2^W-1 (no wrap).
  - When a==0 and cnt!=0: the run ends. Push cnt into the FIFO and set cnt <= 0.
  - When a==0 and cnt==0: no action.
- A run longer than 2^W-1 is reported as 2^W-1.
- A run still open (cnt!=0) is never pushed until a 0 arrives.
- FIFO:
  - DEPTH entries, with read pointer, write pointer and an occupancy count of log2(DEPTH)+1 bits.
  - len_data = storage[rd_ptr]; len_valid = (count!=0).
  - Pop on len_valid && len_ready.
- Push when full:
  - Without a simultaneous pop: drop the run, set lost <= 1, and still clear cnt.
  - With a simultaneous pop: both happen. The count is unchanged and nothing is lost.
- Pop when empty: no effect, since len_valid is low.
- Halt:
  - When up_overflow==1 at an edge, set halted <= 1 (sticky until reset).
  - From that same edge on, cnt is forced to 0 and no further pushes occur. This includes a run that would have ended in the same cycle: it is discarded.
  - The FIFO continues to drain normally.
- Pointers wrap modulo DEPTH.
- lost and halted are cleared only by reset.
- Reset (rst==0): cnt=0, FIFO empty, pointers 0, storage cleared to 0. Outputs after reset: len_valid=0, len_data=0, lost=0, halted=0.
- Reset has priority over every other event, including mid-run and mid-handshake. A pending run is discarded.

## Timing

- Push latency:
  - Run-ending 0 sampled at edge k means the entry is written at edge k.
  - If the FIFO was empty, len_valid=1 and len_data=length from just after edge k.
- Pop: a handshake at edge k gives the next entry (or len_valid=0) just after edge k.
- Throughput:
  - Minimum run spacing is 2 cycles (pattern 1,0), so at most one push per 2 cycles.
  - With len_ready held high, the FIFO never fills.
- len_data must be held stable while len_valid && !len_ready.
- lost and halted rise just after the edge that caused them.
- No combinational path from len_ready to len_valid or len_data.

## Test plan

- Reset then a = 0,1,1,1,0,1,1,0 with len_ready=1 -> pushes 3 then 2. len_valid pulses high one cycle after each terminating 0. lost=0.
- len_ready=0; five runs of length 1 (1,0 repeated five times), DEPTH=4 -> FIFO holds 1,1,1,1 and lost=1 after the 5th terminating 0. Then len_ready=1 -> four pops, then len_valid=0.
- FIFO full (4 entries) and a run of 2 ends in the same cycle as a pop -> no loss, count stays 4, and the last entry read is 2.
- a held 1 for 300 cycles then 0, W=8 -> single entry 255. No wrap to 44.
- Run of length 5 in progress; up_overflow=1 at cycle 3 of the run -> halted=1, no entry pushed. Later runs are ignored, and previously queued entries still drain.
- rst=0 asserted mid-run with 2 entries queued -> len_valid=0, len_data=0, lost=0, halted=0. The next run of 4 yields exactly one entry, 4.

Source files
------------

// File: rtl/token_run_packer.sv
// Measures runs of consecutive '1' tokens and queues each completed run length
// in a small FIFO, presented downstream over a valid/ready handshake.
module token_run_packer #(
  parameter int W     = 8,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         a,
  input  logic         up_overflow,
  output logic [W-1:0] len_data,
  output logic         len_valid,
  input  logic         len_ready,
  output logic         lost,
  output logic         halted
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [W-1:0]  CNT_ONE = W'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   OCC_ONE = (AW + 1)'(1);

  logic [W-1:0]  cnt;
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  logic stop;
  logic run_end;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Outputs come straight from state, so len_ready never reaches len_valid/len_data.
  assign len_valid = (count != '0);
  assign len_data  = mem[rd_ptr];

  always_comb begin
    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    stop    = 1'b0;
    run_end = 1'b0;
    full    = 1'b0;
    pop     = 1'b0;
    push    = 1'b0;
    drop    = 1'b0;

    // The overflow edge itself already suppresses capture, including a run ending now.
    stop    = halted | up_overflow;
    run_end = !a && (cnt != '0) && !stop;
    // DEPTH is a power of two, so the occupancy MSB alone marks "full".
    full    = count[AW];
    pop     = len_valid && len_ready;
    push    = run_end && (!full || pop);
    drop    = run_end && full && !pop;
  end

  always_ff @(posedge clk) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst) begin
      cnt    <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      lost   <= 1'b0;
      halted <= 1'b0;
      // NOTE: storage is cleared on reset so len_data reads 0 afterwards; this rules out RAM macros.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (stop)           cnt <= '0;
      else if (a)         cnt <= (cnt == '1) ? cnt : cnt + CNT_ONE;
      else                cnt <= '0;

      if (push) begin
        mem[wr_ptr] <= cnt;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (pop) rd_ptr <= rd_ptr + PTR_ONE;

      case ({push, pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase

      lost   <= lost | drop;
      halted <= halted | up_overflow;
    end
  end

endmodule

// File: tb/tb_token_run_packer.sv
// Directed bench for token_run_packer (W=8, DEPTH=4); expectations are hand-computed.
module tb_token_run_packer;

  logic       clk;
  logic       rst;
  logic       a;
  logic       up_overflow;
  logic [7:0] len_data;
  logic       len_valid;
  logic       len_ready;
  logic       lost;
  logic       halted;

  int vectors = 0;
  int errors  = 0;

  token_run_packer #(.W(8), .DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .a          (a),
    .up_overflow(up_overflow),
    .len_data   (len_data),
    .len_valid  (len_valid),
    .len_ready  (len_ready),
    .lost       (lost),
    .halted     (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; a = 1'b0; up_overflow = 1'b0; len_ready = 1'b0;
    step();
    step();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", len_valid); end
    vectors++; if (len_data !== 8'd0)  begin errors++; $display("FAIL reset_data got=%0d exp=0", len_data); end
    vectors++; if (lost !== 1'b0)      begin errors++; $display("FAIL reset_lost got=%b exp=0", lost); end
    vectors++; if (halted !== 1'b0)    begin errors++; $display("FAIL reset_halted got=%b exp=0", halted); end
  endtask

  task automatic test_basic();
    logic [7:0] seq;
    logic [7:0] exp_v;
    logic [7:0] exp_d [8];
    seq   = 8'b0110_1110; // applied LSB-first: 0,1,1,1,0,1,1,0
    exp_v = 8'b1001_0000; // valid after edges 4 and 7
    exp_d = '{0, 0, 0, 0, 3, 0, 0, 2};
    do_reset();
    len_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      a = seq[i];
      step();
      vectors++;
      if (len_valid !== exp_v[i]) begin
        errors++; $display("FAIL basic_valid[%0d] got=%b exp=%b", i, len_valid, exp_v[i]);
      end
      if (exp_v[i]) begin
        vectors++;
        if (len_data !== exp_d[i]) begin
          errors++; $display("FAIL basic_data[%0d] got=%0d exp=%0d", i, len_data, exp_d[i]);
        end
      end
    end
    a = 1'b0;
    step();
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL basic_drained got=%b exp=0", len_valid); end
    vectors++; if (lost !== 1'b0)      begin errors++; $display("FAIL basic_lost got=%b exp=0", lost); end
  endtask

  task automatic test_fill_lost();
    do_reset();
    len_ready = 1'b0;
    for (int r = 0; r < 5; r++) begin
      a = 1'b1; step();
      a = 1'b0; step();
      vectors++;
      if (lost !== (r == 4)) begin
        errors++; $display("FAIL fill_lost[%0d] got=%b exp=%b", r, lost, (r == 4));
      end
    end
    len_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (len_valid !== 1'b1 || len_data !== 8'd1) begin
        errors++; $display("FAIL fill_pop[%0d] got valid=%b data=%0d exp valid=1 data=1", i, len_valid, len_data);
      end
      step();
    end
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL fill_empty got=%b exp=0", len_valid); end
    vectors++; if (lost !== 1'b1)      begin errors++; $display("FAIL fill_lost_sticky got=%b exp=1", lost); end
  endtask

  task automatic test_full_push_pop();
    logic [7:0] exp_d [4];
    exp_d = '{1, 1, 1, 2};
    do_reset();
    len_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin
      a = 1'b1; step();
      a = 1'b0; step();
    end
    a = 1'b1; step(); step();
    a = 1'b0; len_ready = 1'b1;
    step(); // run of 2 ends while one entry pops from a full FIFO
    vectors++; if (lost !== 1'b0) begin errors++; $display("FAIL fullpop_lost got=%b exp=0", lost); end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (len_valid !== 1'b1 || len_data !== exp_d[i]) begin
        errors++; $display("FAIL fullpop_drain[%0d] got valid=%b data=%0d exp valid=1 data=%0d", i, len_valid, len_data, exp_d[i]);
      end
      step();
    end
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%b exp=0", len_valid); end
  endtask

  task automatic test_saturate();
    do_reset();
    len_ready = 1'b0;
    a = 1'b1;
    for (int i = 0; i < 300; i++) step();
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL sat_open_run got=%b exp=0", len_valid); end
    a = 1'b0; step();
    vectors++;
    if (len_valid !== 1'b1 || len_data !== 8'd255) begin
      errors++; $display("FAIL sat_len got valid=%b data=%0d exp valid=1 data=255", len_valid, len_data);
    end
    len_ready = 1'b1; step();
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL sat_single got=%b exp=0", len_valid); end
  endtask

  task automatic test_halt();
    // A run ending on the overflow edge is discarded.
    do_reset();
    a = 1'b1; step();
    a = 1'b0; up_overflow = 1'b1; step();
    up_overflow = 1'b0;
    vectors++; if (halted !== 1'b1)    begin errors++; $display("FAIL halt_same_flag got=%b exp=1", halted); end
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL halt_same_push got=%b exp=0", len_valid); end

    // Queued entry survives; a run cut by overflow and later runs are ignored.
    do_reset();
    len_ready = 1'b0;
    a = 1'b1; step(); step();
    a = 1'b0; step();            // entry 2 queued
    a = 1'b1; step(); step();
    up_overflow = 1'b1; step();  // third cycle of the run
    up_overflow = 1'b0;
    vectors++; if (halted !== 1'b1) begin errors++; $display("FAIL halt_flag got=%b exp=1", halted); end
    step(); step();
    a = 1'b0; step();
    a = 1'b1; step(); step();
    a = 1'b0; step();
    vectors++;
    if (len_valid !== 1'b1 || len_data !== 8'd2) begin
      errors++; $display("FAIL halt_head got valid=%b data=%0d exp valid=1 data=2", len_valid, len_data);
    end
    len_ready = 1'b1; step();
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL halt_drain got=%b exp=0", len_valid); end
    vectors++; if (halted !== 1'b1)    begin errors++; $display("FAIL halt_sticky got=%b exp=1", halted); end
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    len_ready = 1'b0;
    for (int r = 0; r < 2; r++) begin
      a = 1'b1; step();
      a = 1'b0; step();
    end
    a = 1'b1; step(); step();    // run of 2 open, 2 entries queued
    rst = 1'b0; len_ready = 1'b1;
    step();
    vectors++;
    if (len_valid !== 1'b0 || len_data !== 8'd0 || lost !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL midrst_state got valid=%b data=%0d lost=%b halted=%b exp 0 0 0 0", len_valid, len_data, lost, halted);
    end
    rst = 1'b1; len_ready = 1'b0;
    a = 1'b1; for (int i = 0; i < 4; i++) step();
    a = 1'b0; step();
    vectors++;
    if (len_valid !== 1'b1 || len_data !== 8'd4) begin
      errors++; $display("FAIL midrst_run got valid=%b data=%0d exp valid=1 data=4", len_valid, len_data);
    end
    len_ready = 1'b1; step();
    vectors++; if (len_valid !== 1'b0) begin errors++; $display("FAIL midrst_single got=%b exp=0", len_valid); end
  endtask

  initial begin
    rst = 1'b0; a = 1'b0; up_overflow = 1'b0; len_ready = 1'b0;
    test_reset();
    test_basic();
    test_fill_lost();
    test_full_push_pop();
    test_saturate();
    test_halt();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
